// File: rtl/invert8_arbiter_if.sv
// Requester and result bus for invert8_arbiter: two requesters in, one result slot out.
// master drives requests and downstream ready; slave is the arbiter.
interface invert8_arbiter_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] i0;
  logic             v0;
  logic             inv0;
  logic             r0;
  logic [WIDTH-1:0] i1;
  logic             v1;
  logic             inv1;
  logic             r1;
  logic [WIDTH-1:0] o;
  logic             ov;
  logic             oready;
  logic             oid;

  modport master (
    output i0, v0, inv0, i1, v1, inv1, oready,
    input  r0, r1, o, ov, oid
  );

  modport slave (
    input  i0, v0, inv0, i1, v1, inv1, oready,
    output r0, r1, o, ov, oid
  );
endinterface

// File: rtl/invert8_arbiter.sv
// Two-requester round-robin arbiter feeding a single-slot output register.
// The granted word is optionally inverted on acceptance and tagged with its requester index.
module invert8_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  invert8_arbiter_if.slave bus
);

  typedef enum logic {StEmpty, StFull} slot_state_e;

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             oid_q, oid_d;
  logic             last_q, last_d;
  logic             slot_free, grant_any, grant_idx, accept, transfer;

  assign bus.ov  = (state_q == StFull);
  assign bus.o   = data_q;
  assign bus.oid = oid_q;

  assign slot_free = !bus.ov || bus.oready;
  assign transfer  = bus.ov && bus.oready;

  // Grant uses only valids and the round-robin pointer so ready never depends on data.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (bus.v0 && bus.v1) begin
      grant_any = 1'b1;
      grant_idx = ~last_q;
    end else if (bus.v0) begin
      grant_any = 1'b1;
    end else if (bus.v1) begin
      grant_any = 1'b1;
      grant_idx = 1'b1;
    end
  end

  assign bus.r0 = slot_free && !reset && grant_any && !grant_idx;
  assign bus.r1 = slot_free && !reset && grant_any && grant_idx;
  assign accept = (bus.v0 && bus.r0) || (bus.v1 && bus.r1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    oid_d   = oid_q;
    last_d  = last_q;
    if (accept) begin
      state_d = StFull;
      oid_d   = grant_idx;
      last_d  = grant_idx;
      if (grant_idx) begin
        data_d = bus.inv1 ? ~bus.i1 : bus.i1;
      end else begin
        data_d = bus.inv0 ? ~bus.i0 : bus.i0;
      end
    end else if (transfer) begin
      state_d = StEmpty;
    end
  end

  // LAST resets to 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
      oid_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      oid_q   <= oid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_invert8_arbiter.sv
// Directed and randomised checks for invert8_arbiter; inputs change on the falling edge,
// ready is checked before the rising edge and registered outputs just after it.
module tb_invert8_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  invert8_arbiter_if #(.WIDTH(8)) bus ();

  invert8_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.v0 = 1'b0; bus.v1 = 1'b0; bus.inv0 = 1'b0; bus.inv1 = 1'b0;
    bus.i0 = 8'h00; bus.i1 = 8'h00; bus.oready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.v0 = 1'b1; bus.v1 = 1'b1; bus.oready = 1'b1;
    #1;
    checks++;
    if ({bus.r0, bus.r1} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got r0r1=%b want 00", {bus.r0, bus.r1});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ov, bus.o, bus.oid} !== {1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got ov=%b o=%h oid=%b want ov=0 o=00 oid=0",
               bus.ov, bus.o, bus.oid);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_invert();
    do_reset();
    bus.v0 = 1'b1; bus.i0 = 8'h0F; bus.inv0 = 1'b1; bus.oready = 1'b1;
    #1;
    checks++;
    if ({bus.r0, bus.r1} !== 2'b10) begin
      failures++;
      $display("FAIL invert_ready: got r0r1=%b want 10", {bus.r0, bus.r1});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ov, bus.o, bus.oid} !== {1'b1, 8'hF0, 1'b0}) begin
      failures++;
      $display("FAIL invert_result: got ov=%b o=%h oid=%b want ov=1 o=f0 oid=0",
               bus.ov, bus.o, bus.oid);
    end
    @(negedge clk);
    bus.v0 = 1'b0;
  endtask

  task automatic test_pass();
    // Slot still holds F0 with oready high, so this acceptance is back-to-back.
    bus.v1 = 1'b1; bus.i1 = 8'hA5; bus.inv1 = 1'b0; bus.oready = 1'b1;
    #1;
    checks++;
    if ({bus.r0, bus.r1} !== 2'b01) begin
      failures++;
      $display("FAIL pass_ready: got r0r1=%b want 01", {bus.r0, bus.r1});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ov, bus.o, bus.oid} !== {1'b1, 8'hA5, 1'b1}) begin
      failures++;
      $display("FAIL pass_result: got ov=%b o=%h oid=%b want ov=1 o=a5 oid=1",
               bus.ov, bus.o, bus.oid);
    end
    @(negedge clk);
    bus.v1 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ov, bus.o, bus.oid} !== {1'b0, 8'hA5, 1'b1}) begin
      failures++;
      $display("FAIL drain_hold: got ov=%b o=%h oid=%b want ov=0 o=a5 oid=1",
               bus.ov, bus.o, bus.oid);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] want_o;
    logic       want_id;
    do_reset();
    bus.v0 = 1'b1; bus.i0 = 8'h11; bus.inv0 = 1'b0;
    bus.v1 = 1'b1; bus.i1 = 8'h22; bus.inv1 = 1'b1;
    bus.oready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      want_id = (k % 2 == 1);
      want_o  = want_id ? 8'hDD : 8'h11;
      #1;
      checks++;
      if ({bus.r0, bus.r1} !== {~want_id, want_id}) begin
        failures++;
        $display("FAIL rr_ready[%0d]: got r0r1=%b want %b", k, {bus.r0, bus.r1},
                 {~want_id, want_id});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus.ov, bus.o, bus.oid} !== {1'b1, want_o, want_id}) begin
        failures++;
        $display("FAIL rr_result[%0d]: got ov=%b o=%h oid=%b want ov=1 o=%h oid=%b",
                 k, bus.ov, bus.o, bus.oid, want_o, want_id);
      end
      @(negedge clk);
    end
    bus.v1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Slot holds DD from requester 1; stall it and offer requester 0.
    bus.v0 = 1'b1; bus.i0 = 8'h3C; bus.inv0 = 1'b1; bus.oready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({bus.r0, bus.r1} !== 2'b00) begin
        failures++;
        $display("FAIL stall_ready[%0d]: got r0r1=%b want 00", k, {bus.r0, bus.r1});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus.ov, bus.o, bus.oid} !== {1'b1, 8'hDD, 1'b1}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got ov=%b o=%h oid=%b want ov=1 o=dd oid=1",
                 k, bus.ov, bus.o, bus.oid);
      end
      @(negedge clk);
    end
    bus.oready = 1'b1;
    #1;
    checks++;
    if ({bus.r0, bus.r1} !== 2'b10) begin
      failures++;
      $display("FAIL release_ready: got r0r1=%b want 10", {bus.r0, bus.r1});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ov, bus.o, bus.oid} !== {1'b1, 8'hC3, 1'b0}) begin
      failures++;
      $display("FAIL release_result: got ov=%b o=%h oid=%b want ov=1 o=c3 oid=0",
               bus.ov, bus.o, bus.oid);
    end
    // Mode flips after acceptance must not touch the held word.
    @(negedge clk);
    bus.v0 = 1'b0; bus.inv0 = 1'b0; bus.oready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ov, bus.o, bus.oid} !== {1'b1, 8'hC3, 1'b0}) begin
      failures++;
      $display("FAIL inv_late: got ov=%b o=%h oid=%b want ov=1 o=c3 oid=0",
               bus.ov, bus.o, bus.oid);
    end
  endtask

  task automatic test_reset_full();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ov, bus.o, bus.oid} !== {1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_full: got ov=%b o=%h oid=%b want ov=0 o=00 oid=0",
               bus.ov, bus.o, bus.oid);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.v0 = 1'b1; bus.i0 = 8'h5A; bus.inv0 = 1'b0;
    bus.v1 = 1'b1; bus.i1 = 8'h77; bus.inv1 = 1'b0; bus.oready = 1'b1;
    #1;
    checks++;
    if ({bus.r0, bus.r1} !== 2'b10) begin
      failures++;
      $display("FAIL first_grant: got r0r1=%b want 10", {bus.r0, bus.r1});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ov, bus.o, bus.oid} !== {1'b1, 8'h5A, 1'b0}) begin
      failures++;
      $display("FAIL first_result: got ov=%b o=%h oid=%b want ov=1 o=5a oid=0",
               bus.ov, bus.o, bus.oid);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    logic       m_ov, m_oid, m_last, m_free, g_any, g_idx;
    logic [7:0] m_o;
    do_reset();
    m_ov = 1'b0; m_o = 8'h00; m_oid = 1'b0; m_last = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bus.v0 = 1'($urandom_range(0, 1)); bus.v1 = 1'($urandom_range(0, 1));
      bus.inv0 = 1'($urandom_range(0, 1)); bus.inv1 = 1'($urandom_range(0, 1));
      bus.i0 = 8'($urandom); bus.i1 = 8'($urandom);
      bus.oready = ($urandom_range(0, 3) != 0);
      m_free = !m_ov || bus.oready;
      g_any  = m_free && (bus.v0 || bus.v1);
      g_idx  = (bus.v0 && bus.v1) ? ~m_last : bus.v1;
      #1;
      checks++;
      if ({bus.r0, bus.r1} !== {g_any && !g_idx, g_any && g_idx}) begin
        failures++;
        $display("FAIL rand_ready[%0d]: got r0r1=%b want %b", k, {bus.r0, bus.r1},
                 {g_any && !g_idx, g_any && g_idx});
      end
      if (g_any) begin
        m_o    = g_idx ? (bus.inv1 ? ~bus.i1 : bus.i1) : (bus.inv0 ? ~bus.i0 : bus.i0);
        m_oid  = g_idx;
        m_last = g_idx;
        m_ov   = 1'b1;
      end else if (m_ov && bus.oready) begin
        m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus.ov, bus.o, bus.oid} !== {m_ov, m_o, m_oid}) begin
        failures++;
        $display("FAIL rand_result[%0d]: got ov=%b o=%h oid=%b want ov=%b o=%h oid=%b",
                 k, bus.ov, bus.o, bus.oid, m_ov, m_o, m_oid);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_invert();
    test_pass();
    test_round_robin();
    test_back_to_back();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/invert8_arbiter.md
INVERT8_ARBITER -- requirements
Module: invert8_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of each requester and of the output.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: I0  input  WIDTH  requester 0 data.
REQ-005 SHALL have port: V0  input  1  requester 0 valid.
REQ-006 SHALL have port: INV0  input  1  requester 0 mode; 1 = invert, 0 = pass.
REQ-007 SHALL have port: R0  output  1  requester 0 ready.
REQ-008 SHALL have ports: I1, V1, INV1, R1, same widths and meanings for requester 1.
REQ-009 SHALL have port: O  output  WIDTH  result data.
REQ-010 SHALL have port: OV  output  1  result valid.
REQ-011 SHALL have port: OREADY  input  1  downstream ready.
REQ-012 SHALL have port: OID  output  1  index of the requester that produced O.

Function
REQ-013 SHALL hold one output slot with two states: EMPTY (OV=0) and FULL (OV=1).
REQ-014 SHALL define slot_free = !OV || OREADY, evaluated combinationally.
REQ-015 SHALL keep a round-robin pointer LAST (1 bit) naming the most recently granted requester.
REQ-016 Grant when slot_free: only V0 -> 0; only V1 -> 1; both -> requester != LAST; neither -> none.
REQ-017 SHALL drive Rk = slot_free && !RESET && (grant == k); at most one of R0/R1 high in any cycle.
REQ-018 Rk SHALL depend combinationally only on OV, OREADY, V0, V1, LAST and RESET, never on data or INV inputs.
REQ-019 SHALL accept requester k when Vk && Rk; on that edge O <= INVk ? ~Ik : Ik (bitwise), OID <= k, OV <= 1, LAST <= k.
REQ-020 Latency SHALL be exactly one cycle from acceptance to OV=1 with the result.
REQ-021 SHALL treat OV && OREADY as an output transfer.
REQ-022 Transfer with no acceptance in the same cycle: OV <= 1'b0 (FULL -> EMPTY); O and OID hold their values.
REQ-023 Transfer and acceptance in the same cycle: OV stays 1 and O/OID take the new result (FULL -> FULL, no bubble).
REQ-024 While FULL and OREADY=0: O, OID and OV SHALL hold stable; R0=R1=0.
REQ-025 LAST SHALL change only on acceptance; a requester deasserting V before acceptance SHALL not move LAST.
REQ-026 Throughput SHALL be one result per cycle when OREADY is held high and any requester is valid.
REQ-027 With both requesters continuously valid and OREADY high, grants SHALL alternate 0,1,0,1,... (no starvation).
REQ-028 INVk SHALL be sampled only on the acceptance edge; later changes SHALL not alter O.

Reset
REQ-029 RESET=1 at a rising edge SHALL set OV=0, O=0, OID=0, LAST=1.
REQ-030 While RESET=1, R0=R1=0 and no acceptance occurs.
REQ-031 RESET asserted while FULL SHALL discard the held result without an output transfer.
REQ-032 On the first cycle after RESET deasserts with V0=V1=1, requester 0 SHALL win.

Verification
REQ-033 Reset, then V0=1, I0=8'h0F, INV0=1, OREADY=1 -> R0=1 that cycle; next cycle OV=1, O=8'hF0, OID=0.
REQ-034 V1=1, I1=8'hA5, INV1=0, OREADY=1 -> next cycle O=8'hA5, OID=1.
REQ-035 V0=V1=1 for 4 cycles after reset, OREADY=1 -> OID sequence 0,1,0,1; OV high continuously from cycle 2.
REQ-036 Slot FULL with OREADY=0 for 3 cycles, V0=1 -> R0=0 throughout, O/OID stable; OREADY=1 -> transfer and new acceptance same cycle, OV remains 1.
REQ-037 RESET pulsed while OV=1 and OREADY=0 -> next cycle OV=0, O=8'h00, LAST=1; V0=V1=1 then grants requester 0 first.
REQ-038 Random stimulus with scoreboard: every accepted item appears on O exactly once, in acceptance order, with correct invert/pass and OID.
